// File: rtl/tx_status_gen_if.sv
// TX status generator bus: attempt/ACK events in from the TX control logic,
// completion record and retransmission request out to the status FIFO side.
interface tx_status_gen_if #(
  parameter int CNT_WIDTH   = 16,
  parameter int RETRY_WIDTH = 4
);

  logic                   tx_start_i;
  logic [1:0]             pkt_prio_i;
  logic [9:0]             pkt_sn_i;
  logic                   pkt_need_ack_i;
  logic [RETRY_WIDTH-1:0] max_retry_i;
  logic [CNT_WIDTH-1:0]   ack_timeout_i;
  logic                   phy_tx_done_i;
  logic                   ack_ok_i;

  logic                   retx_req_o;
  logic                   tx_try_complete;
  logic [RETRY_WIDTH:0]   tx_status;
  logic [1:0]             linux_prio;
  logic [9:0]             tx_pkt_sn;
  logic                   busy_o;

  // TX control logic / testbench side
  modport master (
    output tx_start_i, pkt_prio_i, pkt_sn_i, pkt_need_ack_i,
           max_retry_i, ack_timeout_i, phy_tx_done_i, ack_ok_i,
    input  retx_req_o, tx_try_complete, tx_status, linux_prio,
           tx_pkt_sn, busy_o
  );

  // Status generator side
  modport slave (
    input  tx_start_i, pkt_prio_i, pkt_sn_i, pkt_need_ack_i,
           max_retry_i, ack_timeout_i, phy_tx_done_i, ack_ok_i,
    output retx_req_o, tx_try_complete, tx_status, linux_prio,
           tx_pkt_sn, busy_o
  );

endinterface

// File: rtl/tx_status_gen.sv
// Per-packet transmit outcome tracker. Follows a packet through PHY attempts,
// ACK windows and retransmissions, then emits a one-cycle completion pulse
// together with a held record {fail, retrans_cnt}, priority and sequence number.
module tx_status_gen #(
  parameter int CNT_WIDTH   = 16,
  parameter int RETRY_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  tx_status_gen_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT_ACK,
    S_RETRY_WAIT,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_prio;
  logic [9:0]             r_sn;
  logic                   r_needAck;
  logic [RETRY_WIDTH-1:0] r_maxRetry;
  logic [RETRY_WIDTH-1:0] r_retransCnt;
  logic [CNT_WIDTH-1:0]   r_ackCnt;

  logic                   r_retxReq;
  logic                   r_tryComplete;
  logic [RETRY_WIDTH:0]   r_status;
  logic [1:0]             r_outPrio;
  logic [9:0]             r_outSn;

  logic [CNT_WIDTH-1:0]   w_timeoutLast;
  logic                   w_timeoutHit;
  logic                   w_canRetry;
  logic                   w_finish;
  logic                   w_fail;
  logic                   w_retry;

  // A zero timeout behaves as a one-cycle window, so the last counter value is 0.
  assign w_timeoutLast = (bus.ack_timeout_i == '0) ? '0 : (bus.ack_timeout_i - 1'b1);
  // Compare with >= so a window shrunk mid-wait still expires instead of wrapping.
  assign w_timeoutHit  = (r_ackCnt >= w_timeoutLast);
  assign w_canRetry    = (r_retransCnt < r_maxRetry);

  // Decide whether this cycle ends the packet (and how) or starts a retry; ACK beats timeout.
  always_comb begin
    w_finish = 1'b0;
    w_fail   = 1'b0;
    w_retry  = 1'b0;
    case (r_state)
      S_TX: begin
        if (bus.phy_tx_done_i && !r_needAck) begin
          w_finish = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (bus.ack_ok_i) begin
          w_finish = 1'b1;
        end else if (w_timeoutHit) begin
          if (w_canRetry) begin
            w_retry = 1'b1;
          end else begin
            w_finish = 1'b1;
            w_fail   = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Packet FSM with registered pulses and the completion record that holds until the next DONE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_prio        <= '0;
      r_sn          <= '0;
      r_needAck     <= 1'b0;
      r_maxRetry    <= '0;
      r_retransCnt  <= '0;
      r_ackCnt      <= '0;
      r_retxReq     <= 1'b0;
      r_tryComplete <= 1'b0;
      r_status      <= '0;
      r_outPrio     <= '0;
      r_outSn       <= '0;
    end else begin
      r_retxReq     <= 1'b0;
      r_tryComplete <= 1'b0;

      if (w_finish) begin
        r_tryComplete <= 1'b1;
        r_status      <= {w_fail, r_retransCnt};
        r_outPrio     <= r_prio;
        r_outSn       <= r_sn;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.tx_start_i) begin
            r_prio       <= bus.pkt_prio_i;
            r_sn         <= bus.pkt_sn_i;
            r_needAck    <= bus.pkt_need_ack_i;
            r_maxRetry   <= bus.max_retry_i;
            r_retransCnt <= '0;
            r_state      <= S_TX;
          end
        end
        S_TX: begin
          if (bus.phy_tx_done_i) begin
            if (r_needAck) begin
              r_ackCnt <= '0;
              r_state  <= S_WAIT_ACK;
            end else begin
              r_state  <= S_DONE;
            end
          end
        end
        S_WAIT_ACK: begin
          if (w_finish) begin
            r_state <= S_DONE;
          end else if (w_retry) begin
            r_retxReq    <= 1'b1;
            r_retransCnt <= r_retransCnt + 1'b1;
            r_state      <= S_RETRY_WAIT;
          end else begin
            r_ackCnt <= r_ackCnt + 1'b1;
          end
        end
        S_RETRY_WAIT: begin
          if (bus.tx_start_i) begin
            r_state <= S_TX;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.retx_req_o      = r_retxReq;
  assign bus.tx_try_complete = r_tryComplete;
  assign bus.tx_status       = r_status;
  assign bus.linux_prio      = r_outPrio;
  assign bus.tx_pkt_sn       = r_outSn;
  assign bus.busy_o          = (r_state != S_IDLE);

endmodule

// File: tb/tb_tx_status_gen.sv
// Directed bench for tx_status_gen: broadcast, ACK, retry, exhaustion,
// corner cases and mid-packet reset, with hand-computed expected records.
module tb_tx_status_gen;

  logic clk;
  logic rstn;
  int   assertCount;
  int   failCount;
  int   retxCount;
  int   tryCount;
  int   retxBase;
  int   tryBase;

  tx_status_gen_if #(.CNT_WIDTH(16), .RETRY_WIDTH(4)) bus ();

  tx_status_gen #(.CNT_WIDTH(16), .RETRY_WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count output pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.retx_req_o)      retxCount++;
    if (bus.tx_try_complete) tryCount++;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present packet fields and pulse tx_start for one cycle.
  task automatic applyStimulus(input logic [1:0] prio, input logic [9:0] sn, input logic needAck,
                               input logic [3:0] maxRetry, input logic [15:0] timeout);
    bus.pkt_prio_i     = prio;
    bus.pkt_sn_i       = sn;
    bus.pkt_need_ack_i = needAck;
    bus.max_retry_i    = maxRetry;
    bus.ack_timeout_i  = timeout;
    bus.tx_start_i     = 1'b1;
    tick();
    bus.tx_start_i     = 1'b0;
  endtask

  task automatic phyDone();
    bus.phy_tx_done_i = 1'b1;
    tick();
    bus.phy_tx_done_i = 1'b0;
  endtask

  task automatic ackPulse();
    bus.ack_ok_i = 1'b1;
    tick();
    bus.ack_ok_i = 1'b0;
  endtask

  // Retransmission start with scrambled packet fields, which must not be re-sampled.
  task automatic retransmit();
    bus.pkt_prio_i     = 2'd0;
    bus.pkt_sn_i       = 10'h3FF;
    bus.pkt_need_ack_i = 1'b0;
    bus.tx_start_i     = 1'b1;
    tick();
    bus.tx_start_i     = 1'b0;
    phyDone();
  endtask

  // Sit in WAIT_ACK for a full window; retx_req_o must appear exactly at its end.
  task automatic expectTimeout(input string tag, input int window);
    repeat (window - 1) tick();
    checkOutput({tag, "_early"}, bus.retx_req_o, 1'b0);
    tick();
    checkOutput(tag, bus.retx_req_o, 1'b1);
    tick();
    checkOutput({tag, "_drop"}, bus.retx_req_o, 1'b0);
  endtask

  task automatic checkRecord(input string tag, input logic [4:0] status, input logic [1:0] prio, input logic [9:0] sn);
    checkOutput({tag, "_status"}, bus.tx_status, status);
    checkOutput({tag, "_prio"}, bus.linux_prio, prio);
    checkOutput({tag, "_sn"}, bus.tx_pkt_sn, sn);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    retxCount   = 0;
    tryCount    = 0;
    rstn               = 1'b0;
    bus.tx_start_i     = 1'b0;
    bus.pkt_prio_i     = '0;
    bus.pkt_sn_i       = '0;
    bus.pkt_need_ack_i = 1'b0;
    bus.max_retry_i    = '0;
    bus.ack_timeout_i  = '0;
    bus.phy_tx_done_i  = 1'b0;
    bus.ack_ok_i       = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_try", bus.tx_try_complete, 1'b0);
    checkOutput("rst_retx", bus.retx_req_o, 1'b0);
    checkOutput("rst_busy", bus.busy_o, 1'b0);
    checkRecord("rst", 5'h00, 2'd0, 10'h000);
    rstn = 1'b1;
    tick();

    // Stray ACK and PHY done in IDLE do nothing
    bus.ack_ok_i = 1'b1;
    bus.phy_tx_done_i = 1'b1;
    tick();
    bus.ack_ok_i = 1'b0;
    bus.phy_tx_done_i = 1'b0;
    checkOutput("idle_stray_busy", bus.busy_o, 1'b0);
    checkOutput("idle_stray_try", bus.tx_try_complete, 1'b0);

    // Broadcast with stray ACK and a second tx_start while in TX
    tryBase = tryCount;
    applyStimulus(2'd2, 10'h155, 1'b0, 4'd0, 16'd20);
    checkOutput("bc_busy", bus.busy_o, 1'b1);
    ackPulse();
    checkOutput("bc_stray_ack_try", bus.tx_try_complete, 1'b0);
    applyStimulus(2'd1, 10'h0AA, 1'b1, 4'd5, 16'd20);
    checkOutput("bc_start_in_tx_busy", bus.busy_o, 1'b1);
    phyDone();
    checkOutput("bc_try", bus.tx_try_complete, 1'b1);
    checkRecord("bc", 5'h00, 2'd2, 10'h155);
    tick();
    checkOutput("bc_try_drop", bus.tx_try_complete, 1'b0);
    checkOutput("bc_idle", bus.busy_o, 1'b0);
    repeat (10) tick();
    checkRecord("bc_hold", 5'h00, 2'd2, 10'h155);
    checkOutput("bc_pulses", tryCount - tryBase, 1);

    // Unicast, ACK on the 5th WAIT_ACK cycle
    retxBase = retxCount;
    applyStimulus(2'd1, 10'h3A5, 1'b1, 4'd3, 16'd20);
    phyDone();
    repeat (4) tick();
    checkOutput("uc_wait_try", bus.tx_try_complete, 1'b0);
    ackPulse();
    checkOutput("uc_try", bus.tx_try_complete, 1'b1);
    checkRecord("uc", 5'h00, 2'd1, 10'h3A5);
    checkOutput("uc_retx", retxCount - retxBase, 0);
    tick();

    // Two retries then ACK, retransmissions carry scrambled fields
    retxBase = retxCount;
    applyStimulus(2'd3, 10'h001, 1'b1, 4'd3, 16'd8);
    phyDone();
    expectTimeout("r2_t1", 8);
    retransmit();
    expectTimeout("r2_t2", 8);
    retransmit();
    tick();
    tick();
    ackPulse();
    checkOutput("r2_try", bus.tx_try_complete, 1'b1);
    checkRecord("r2", 5'h02, 2'd3, 10'h001);
    checkOutput("r2_retx", retxCount - retxBase, 2);
    tick();

    // Retries exhausted with max_retry=2
    retxBase = retxCount;
    applyStimulus(2'd0, 10'h2F0, 1'b1, 4'd2, 16'd5);
    phyDone();
    expectTimeout("ex_t1", 5);
    retransmit();
    expectTimeout("ex_t2", 5);
    retransmit();
    repeat (4) tick();
    checkOutput("ex_early_try", bus.tx_try_complete, 1'b0);
    tick();
    checkOutput("ex_try", bus.tx_try_complete, 1'b1);
    checkOutput("ex_no_retx", bus.retx_req_o, 1'b0);
    checkRecord("ex", 5'h12, 2'd0, 10'h2F0);
    checkOutput("ex_retx", retxCount - retxBase, 2);
    tick();

    // Single attempt with max_retry=0
    retxBase = retxCount;
    applyStimulus(2'd1, 10'h111, 1'b1, 4'd0, 16'd3);
    phyDone();
    repeat (2) tick();
    checkOutput("m0_early_try", bus.tx_try_complete, 1'b0);
    tick();
    checkOutput("m0_try", bus.tx_try_complete, 1'b1);
    checkRecord("m0", 5'h10, 2'd1, 10'h111);
    checkOutput("m0_retx", retxCount - retxBase, 0);
    tick();

    // ACK in the same cycle as the timeout wins
    retxBase = retxCount;
    applyStimulus(2'd2, 10'h222, 1'b1, 4'd2, 16'd4);
    phyDone();
    repeat (3) tick();
    ackPulse();
    checkOutput("race_try", bus.tx_try_complete, 1'b1);
    checkRecord("race", 5'h00, 2'd2, 10'h222);
    checkOutput("race_retx", retxCount - retxBase, 0);
    tick();

    // Zero timeout is a one-cycle window; ACK in RETRY_WAIT ignored
    retxBase = retxCount;
    applyStimulus(2'd3, 10'h333, 1'b1, 4'd1, 16'd0);
    phyDone();
    tick();
    checkOutput("t0_retx", bus.retx_req_o, 1'b1);
    ackPulse();
    checkOutput("t0_rw_ack_try", bus.tx_try_complete, 1'b0);
    checkOutput("t0_rw_busy", bus.busy_o, 1'b1);
    retransmit();
    tick();
    checkOutput("t0_try", bus.tx_try_complete, 1'b1);
    checkRecord("t0", 5'h11, 2'd3, 10'h333);
    checkOutput("t0_retx_total", retxCount - retxBase, 1);
    tick();

    // Reset during WAIT_ACK abandons the packet
    tryBase = tryCount;
    retxBase = retxCount;
    applyStimulus(2'd2, 10'h0F0, 1'b1, 4'd1, 16'd10);
    phyDone();
    tick();
    rstn = 1'b0;
    tick();
    checkOutput("mrst_busy", bus.busy_o, 1'b0);
    checkOutput("mrst_try", bus.tx_try_complete, 1'b0);
    checkRecord("mrst", 5'h00, 2'd0, 10'h000);
    rstn = 1'b1;
    repeat (12) tick();
    checkOutput("mrst_no_pulse", tryCount - tryBase, 0);
    checkOutput("mrst_no_retx", retxCount - retxBase, 0);

    // Next packet after reset completes normally
    applyStimulus(2'd1, 10'h2C3, 1'b0, 4'd0, 16'd1);
    phyDone();
    checkOutput("post_try", bus.tx_try_complete, 1'b1);
    checkRecord("post", 5'h00, 2'd1, 10'h2C3);
    tick();
    checkOutput("post_idle", bus.busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
